riscv_ifu: RTL

- Instruction fetch unit. Generates the sequential fetch PC, issues single-beat AXI4 read requests, buffers returned words in a small in-order FIFO, and presents them on the ifu_vld/ifu_addr/ifu_data interface consumed by riscv_idu.
- Accepts redirects from the execute stage. On a redirect it flushes buffered and in-flight fetches and restarts at the new address.

---
 rtl/riscv_ifu.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_ifu.sv
// riscv_ifu: instruction fetch unit.
//
// Walks a sequential fetch PC and issues single-beat AXI4 reads. Returned words
// are kept in a small in-order FIFO and presented to the decode stage on the
// ifu_vld/ifu_addr/ifu_data/ifu_fault interface. A redirect flushes the FIFO
// and restarts fetch at the new address. Any response to a request issued
// before the redirect is counted in drop_cnt and thrown away when it arrives.
//
// Ports:
//   clock, reset_n           clock (rising edge), asynchronous active-low reset
//   redir_vld, redir_addr    redirect request and target (bits [1:0] ignored)
//   arvalid/arready/araddr   AXI4 AR channel; arlen/arsize/arburst are constant
//   rvalid/rready/rdata/rresp AXI4 R channel; rready is tied high
//   ifu_vld/ifu_rdy          instruction handshake with the decode stage
//   ifu_addr/ifu_data        PC and word at the FIFO head
//   ifu_fault                head word came back with rresp != OKAY
//
// Optional build feature (macro RISCV_IFU_PERF_EN):
//   perf_fetch_cnt           +1 per instruction popped
//   perf_stall_cnt           +1 per cycle with the FIFO empty and no redirect

module riscv_ifu #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redir_vld,
    input  logic [31:0] redir_addr,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        ifu_vld,
    input  logic        ifu_rdy,
    output logic [31:0] ifu_addr,
    output logic [31:0] ifu_data,
    output logic        ifu_fault
`ifdef RISCV_IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int DROP_W = $clog2(MAX_OUTSTANDING + 2);

    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [31:0]      DEPTH_32 = 32'(FIFO_DEPTH);

    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [31:0]       stale_addr;
    logic              ar_stale;
    logic              arvalid_q;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  out_next;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  cnt_next;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [31:0]           fifo_addr [FIFO_DEPTH];
    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_fault;

    logic        fifo_empty;
    logic        ar_fire;
    logic        ar_hold;
    logic        push;
    logic        pop;
    logic        arvalid_next;
    logic [31:0] redir_pc;
    logic [31:0] pending_sum;
    logic        unused_redir_bits;

    assign redir_pc          = {redir_addr[31:2], 2'b00};
    assign unused_redir_bits = ^redir_addr[1:0];

    assign fifo_empty = (fifo_count == '0);
    assign ar_fire    = arvalid_q && arready;
    assign ar_hold    = arvalid_q && !arready;

    // A beat is discarded if it arrives in a redirect cycle or while older
    // stale requests are still being drained.
    assign push = rvalid && !redir_vld && (drop_cnt == '0);
    assign pop  = ifu_vld && ifu_rdy;

    assign arvalid = arvalid_q;
    // A request held across a redirect keeps its original address until accepted.
    assign araddr  = ar_stale ? stale_addr : fetch_pc;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign rready  = 1'b1;

    assign ifu_vld   = !fifo_empty && !redir_vld;
    assign ifu_addr  = fifo_addr[rd_ptr];
    assign ifu_data  = fifo_data[rd_ptr];
    assign ifu_fault = ifu_vld && fifo_fault[rd_ptr];

    // Next-state bookkeeping. FIFO space is reserved when a request is issued,
    // so the issue check looks at buffered plus in-flight words after this
    // cycle's updates.
    always_comb begin
        out_next = outstanding;
        if (ar_fire && !rvalid) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!ar_fire && rvalid) begin
            out_next = outstanding - OUT_W'(1);
        end

        cnt_next = fifo_count;
        if (redir_vld) begin
            cnt_next = '0;
        end else if (push && !pop) begin
            cnt_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_next = fifo_count - CNT_W'(1);
        end

        drop_next = drop_cnt;
        if (redir_vld) begin
            drop_next = DROP_W'(out_next) + DROP_W'(ar_hold);
        end else if (rvalid && (drop_cnt != '0)) begin
            drop_next = drop_cnt - DROP_W'(1);
        end

        pending_sum  = 32'(cnt_next) + 32'(out_next);
        arvalid_next = ar_hold || ((out_next < MAX_OUT) && (pending_sum < DEPTH_32));
    end

    // Control state: PCs, counters, pointers and the AR request register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            stale_addr  <= '0;
            ar_stale    <= 1'b0;
            arvalid_q   <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            arvalid_q   <= arvalid_next;
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            fifo_count  <= cnt_next;

            if (redir_vld && ar_hold) begin
                ar_stale   <= 1'b1;
                stale_addr <= araddr;
            end else if (ar_fire) begin
                ar_stale <= 1'b0;
            end

            if (redir_vld) begin
                fetch_pc <= redir_pc;
            end else if (ar_fire && !ar_stale) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (redir_vld) begin
                resp_pc <= redir_pc;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage; validity is tracked by fifo_count so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= resp_pc;
            fifo_data[wr_ptr]  <= rdata;
            fifo_fault[wr_ptr] <= (rresp != 2'b00);
        end
    end

`ifdef RISCV_IFU_PERF_EN
    // Free-running performance counters, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (fifo_empty && !redir_vld) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
